// File: rtl/blake_pkg.sv
// Shared constants, FSM encoding and width helper for the BLAKE round sequencer.
// No logic, no latency; nothing here carries flow control.
package blake_pkg;

  localparam int ROUNDS_M0_DEF    = 14;
  localparam int ROUNDS_M1_DEF    = 16;
  localparam int SIGMA_PERIOD_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index widths never drop below one bit, even for degenerate moduli.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/blake_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the terminal count.
// Updates on the edge after clr/en; holds its value whenever en is low.
module blake_mod_counter #(
  parameter int MOD = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = (cnt_q == W'(MOD - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blake_round_sequencer.sv
// Steps a BLAKE compression through rounds x G-steps, exporting step/round/sigma indices.
// One advance per step, done one cycle after the last step; advance low stalls everything.
module blake_round_sequencer
  import blake_pkg::*;
#(
  parameter int  STEPS_PER_ROUND = 8,
  parameter int  ROUNDS_M0       = ROUNDS_M0_DEF,
  parameter int  ROUNDS_M1       = ROUNDS_M1_DEF,
  parameter int  SIGMA_PERIOD    = SIGMA_PERIOD_DEF,
  localparam int RMAX            = (ROUNDS_M0 > ROUNDS_M1) ? ROUNDS_M0 : ROUNDS_M1,
  localparam int SW              = clog2_min1(STEPS_PER_ROUND),
  localparam int RW              = clog2_min1(RMAX),
  localparam int GW              = clog2_min1(SIGMA_PERIOD)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          mode,
  input  logic          advance,
  input  logic          abort,
  output logic [SW-1:0] step_idx,
  output logic [RW-1:0] round_idx,
  output logic [GW-1:0] sigma_idx,
  output logic          busy,
  output logic          last_step,
  output logic          done,
  output logic          rdy
);

  if (STEPS_PER_ROUND < 2) begin : g_bad_steps
    $error("blake_round_sequencer: STEPS_PER_ROUND must be at least 2");
  end
  if (ROUNDS_M0 < 1 || ROUNDS_M0 > (1 << RW)) begin : g_bad_m0
    $error("blake_round_sequencer: ROUNDS_M0 out of range");
  end
  if (ROUNDS_M1 < 1 || ROUNDS_M1 > (1 << RW)) begin : g_bad_m1
    $error("blake_round_sequencer: ROUNDS_M1 out of range");
  end
  if (SIGMA_PERIOD < 1) begin : g_bad_sigma
    $error("blake_round_sequencer: SIGMA_PERIOD must be at least 1");
  end

  localparam logic [RW:0] NR_M0 = (RW + 1)'(ROUNDS_M0);
  localparam logic [RW:0] NR_M1 = (RW + 1)'(ROUNDS_M1);

  state_t      state_q;
  state_t      state_d;
  logic [RW:0] nrounds_q;
  logic [RW:0] nrounds_d;
  logic        done_q;
  logic        done_d;
  logic        rdy_q;
  logic        rdy_d;

  logic        is_run;
  logic        final_round;
  logic        accept;
  logic        run_step;
  logic        finish;
  logic        clr_idx;
  logic        step_wrap;
  logic        round_wrap;
  logic        sigma_wrap;
  logic        unused_wraps;

  assign is_run      = (state_q == ST_RUN);
  assign final_round = ({1'b0, round_idx} == (nrounds_q - 1'b1));
  assign last_step   = is_run && step_wrap && final_round;

  // abort outranks both start and advance; every way out of RUN re-zeros the indices.
  assign accept   = !is_run && start && !abort;
  assign run_step = is_run && advance && !abort;
  assign finish   = run_step && last_step;
  assign clr_idx  = accept || finish || (is_run && abort);

  blake_mod_counter #(
    .MOD (STEPS_PER_ROUND),
    .W   (SW)
  ) u_step_cnt (
    .clk  (clk),
    .rstb (rstb),
    .clr  (clr_idx),
    .en   (run_step),
    .cnt  (step_idx),
    .wrap (step_wrap)
  );

  blake_mod_counter #(
    .MOD (RMAX),
    .W   (RW)
  ) u_round_cnt (
    .clk  (clk),
    .rstb (rstb),
    .clr  (clr_idx),
    .en   (run_step && step_wrap),
    .cnt  (round_idx),
    .wrap (round_wrap)
  );

  blake_mod_counter #(
    .MOD (SIGMA_PERIOD),
    .W   (GW)
  ) u_sigma_cnt (
    .clk  (clk),
    .rstb (rstb),
    .clr  (clr_idx),
    .en   (run_step && step_wrap),
    .cnt  (sigma_idx),
    .wrap (sigma_wrap)
  );

  // The run ends on last_step, so the round/sigma terminal flags are never consumed.
  assign unused_wraps = round_wrap ^ sigma_wrap;

  always_comb begin
    state_d   = state_q;
    nrounds_d = nrounds_q;
    done_d    = 1'b0;
    rdy_d     = rdy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_RUN;
          nrounds_d = mode ? NR_M1 : NR_M0;
          rdy_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      nrounds_q <= NR_M0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nrounds_q <= nrounds_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
    end
  end

  assign busy = is_run;
  assign done = done_q;
  assign rdy  = rdy_q;

endmodule

// File: tb/tb_blake_round_sequencer.sv
// Directed-plus-random bench for blake_round_sequencer against a step-count reference model.
module tb_blake_round_sequencer;

  localparam int S   = 8;
  localparam int NR0 = 14;
  localparam int NR1 = 16;
  localparam int P   = 10;

  logic       clk     = 1'b0;
  logic       rstb    = 1'b1;
  logic       start   = 1'b0;
  logic       mode    = 1'b0;
  logic       advance = 1'b0;
  logic       abort   = 1'b0;
  logic [2:0] step_idx;
  logic [3:0] round_idx;
  logic [3:0] sigma_idx;
  logic       busy;
  logic       last_step;
  logic       done;
  logic       rdy;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is just a count of accepted advances, m_k in [0, m_nr*S).
  bit m_busy;
  bit m_rdy;
  bit m_done;
  int m_k;
  int m_nr;

  int exp_sig[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5};
  int sq[$];

  always #5 clk = ~clk;

  blake_round_sequencer dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .mode      (mode),
    .advance   (advance),
    .abort     (abort),
    .step_idx  (step_idx),
    .round_idx (round_idx),
    .sigma_idx (sigma_idx),
    .busy      (busy),
    .last_step (last_step),
    .done      (done),
    .rdy       (rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_rdy  = 1'b0;
    m_done = 1'b0;
    m_k    = 0;
    m_nr   = NR0;
  endtask

  task automatic check_all();
    chk("step_idx",  32'(step_idx),  32'(m_k % S));
    chk("round_idx", 32'(round_idx), 32'(m_k / S));
    chk("sigma_idx", 32'(sigma_idx), 32'((m_k / S) % P));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("done",      32'(done),      32'(m_done));
    chk("rdy",       32'(rdy),       32'(m_rdy));
    chk("last_step", 32'(last_step), 32'(m_busy && (m_k == m_nr * S - 1)));
  endtask

  task automatic cyc(input bit s, input bit md, input bit adv, input bit ab);
    start   = s;
    mode    = md;
    advance = adv;
    abort   = ab;
    m_done  = 1'b0;
    if (!m_busy) begin
      if (s && !ab) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_nr   = md ? NR1 : NR0;
        m_rdy  = 1'b0;
      end
    end else if (ab) begin
      m_busy = 1'b0;
      m_k    = 0;
    end else if (adv) begin
      if (m_k == m_nr * S - 1) begin
        m_busy = 1'b0;
        m_k    = 0;
        m_rdy  = 1'b1;
        m_done = 1'b1;
      end else begin
        m_k++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int n;
    int hi;
    int maxr;
    bit a;

    // Reset state, visible before any clock edge.
    model_reset();
    #1 rstb = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1 rstb = 1'b1;
    check_all();
    cyc(1'b0, 1'b1, 1'b1, 1'b0);

    // Mode 0 run: 1 accept + 112 steps; mode wiggles during RUN must not matter.
    n = 1;
    maxr = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    while (!done && n < 200) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n++;
      if (int'(round_idx) > maxr) maxr = int'(round_idx);
    end
    chk("m0_latency", 32'(n), 32'd113);
    chk("m0_max_round", 32'(maxr), 32'd13);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("m0_rdy_after", 32'(rdy), 32'd1);

    // Mode 1 run with the sigma value recorded at the start of each round.
    sq.delete();
    n = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    if (busy && step_idx == 3'd0) sq.push_back(int'(sigma_idx));
    while (!done && n < 300) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n++;
      if (busy && step_idx == 3'd0 && sq.size() == int'(round_idx)) sq.push_back(int'(sigma_idx));
    end
    chk("m1_advances", 32'(n), 32'd128);
    chk("sigma_count", 32'(sq.size()), 32'd16);
    for (int i = 0; i < sq.size() && i < 16; i++) chk("sigma_seq", 32'(sq[i]), 32'(exp_sig[i]));

    // Stall: advance low every third cycle.
    n = 0;
    hi = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    while (!done && n < 500) begin
      a = ((n % 3) != 2);
      cyc(1'b0, 1'b1, a, 1'b0);
      n++;
      if (a) hi++;
    end
    chk("stall_hi_advances", 32'(hi), 32'd128);
    chk("stall_total_cycles", 32'(n), 32'd191);

    // Abort at round 5 step 3, with start and advance also high on that cycle.
    n = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    while (m_k != 5 * S + 3 && n < 100) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    chk("abort_at_round", 32'(round_idx), 32'd5);
    chk("abort_at_step", 32'(step_idx), 32'd3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("abort_blocks_start", 32'(busy), 32'd0);
    n = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    while (!done && n < 200) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    chk("fresh_m0_advances", 32'(n), 32'd112);
    chk("fresh_rdy", 32'(rdy), 32'd1);

    // Mid-run reset at round 7, mode toggling during the run.
    n = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    while (m_k != 7 * S && n < 100) begin
      cyc(1'b0, 1'(n % 2), 1'b1, 1'b0);
      n++;
    end
    chk("prerst_round", 32'(round_idx), 32'd7);
    #2 rstb = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2 rstb = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: start held high through done.
    n = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    while (!done && n < 300) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      n++;
    end
    chk("b2b_first_advances", 32'(n), 32'd128);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    chk("b2b_restart_rdy", 32'(rdy), 32'd0);
    n = 0;
    while (!done && n < 300) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      n++;
    end
    chk("b2b_second_advances", 32'(n), 32'd128);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
